// File: rtl/operand_fetch.sv
// Operand-fetch stage: regfile read, EX/MEM forwarding, load-use bubble
// insertion and the ID/EX pipeline register with valid/ready handshakes.
module operand_fetch #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [RA_W-1:0]  in_rs1,
    input  logic [RA_W-1:0]  in_rs2,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_rd_we,
    input  logic             in_is_load,
    output logic [RA_W-1:0]  rf_read1,
    output logic [RA_W-1:0]  rf_read2,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    input  logic             ex_fwd_valid,
    input  logic [RA_W-1:0]  ex_fwd_rd,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic             mem_fwd_valid,
    input  logic [RA_W-1:0]  mem_fwd_rd,
    input  logic [XLEN-1:0]  mem_fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_rd_we,
    output logic             out_is_load,
    output logic [CNT_W-1:0] stall_cnt
);

    // Youngest producer wins: EX before MEM before the regfile; x0 is always 0.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] rs,
        input logic [XLEN-1:0] rf,
        input logic            exv,
        input logic [RA_W-1:0] exrd,
        input logic [XLEN-1:0] exd,
        input logic            memv,
        input logic [RA_W-1:0] memrd,
        input logic [XLEN-1:0] memd
    );
        if (rs == '0)                   return '0;
        else if (exv && exrd == rs)     return exd;
        else if (memv && memrd == rs)   return memd;
        else                            return rf;
    endfunction

    // Saturating increment for the bubble counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic             vld_p1;
    logic [XLEN-1:0]  pc_p1, imm_p1, op1_p1, op2_p1;
    logic [RA_W-1:0]  rd_p1;
    logic             rd_we_p1, is_load_p1;
    logic [CNT_W-1:0] stall_cnt_p1;

    logic [XLEN-1:0]  op1_p0, op2_p0;
    logic             adv, hazard, accept;

    assign rf_read1 = in_rs1;
    assign rf_read2 = in_rs2;

    // ---- p0: operand resolution and handshake ----
    // Resolve operands and decide whether the incoming instruction can enter ID/EX.
    always_comb begin
        op1_p0 = fwd_sel(in_rs1, rf_data1, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                         mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
        op2_p0 = fwd_sel(in_rs2, rf_data2, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                         mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
        adv    = !vld_p1 || out_ready;
        hazard = in_valid && vld_p1 && is_load_p1 && (rd_p1 != '0) && rd_we_p1 &&
                 ((in_use_rs1 && in_rs1 == rd_p1) || (in_use_rs2 && in_rs2 == rd_p1));
        in_ready = adv && !hazard && !flush;
        accept   = in_valid && in_ready;
    end

    // ---- p1: ID/EX register ----
    // ID/EX register update: flush, accept, load-use bubble, drain, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            imm_p1       <= '0;
            op1_p1       <= '0;
            op2_p1       <= '0;
            rd_p1        <= '0;
            rd_we_p1     <= 1'b0;
            is_load_p1   <= 1'b0;
            stall_cnt_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1     <= 1'b1;
            pc_p1      <= in_pc;
            imm_p1     <= in_imm;
            op1_p1     <= op1_p0;
            op2_p1     <= op2_p0;
            rd_p1      <= in_rd;
            rd_we_p1   <= in_rd_we;
            is_load_p1 <= in_is_load;
        end else if (adv && hazard) begin
            vld_p1       <= 1'b0;
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end else if (adv) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_pc      = pc_p1;
    assign out_imm     = imm_p1;
    assign out_rs1_val = op1_p1;
    assign out_rs2_val = op2_p1;
    assign out_rd      = rd_p1;
    assign out_rd_we   = rd_we_p1;
    assign out_is_load = is_load_p1;
    assign stall_cnt   = stall_cnt_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: regfile read, forwarding priority,
// load-use bubbles, back-pressure, flush, async reset and counter saturation.
module tb_operand_fetch;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc, in_imm;
    logic [RA_W-1:0]  in_rs1, in_rs2, in_rd;
    logic             in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
    logic [RA_W-1:0]  rf_read1, rf_read2;
    logic [XLEN-1:0]  rf_data1, rf_data2;
    logic             ex_fwd_valid, mem_fwd_valid;
    logic [RA_W-1:0]  ex_fwd_rd, mem_fwd_rd;
    logic [XLEN-1:0]  ex_fwd_data, mem_fwd_data;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_pc, out_imm, out_rs1_val, out_rs2_val;
    logic [RA_W-1:0]  out_rd;
    logic             out_rd_we, out_is_load;
    logic [CNT_W-1:0] stall_cnt;

    logic [XLEN-1:0]  rf_mem [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Regfile model: combinational read, x0 hardwired to zero.
    assign rf_data1 = (rf_read1 == '0) ? '0 : rf_mem[rf_read1];
    assign rf_data2 = (rf_read2 == '0) ? '0 : rf_mem[rf_read2];

    operand_fetch #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc,
                         input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                         input logic u1, input logic u2,
                         input logic [RA_W-1:0] rd, input logic we, input logic ld);
        in_valid = v; in_pc = pc; in_imm = pc + 32'h4;
        in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = u1; in_use_rs2 = u2;
        in_rd = rd; in_rd_we = we; in_is_load = ld;
    endtask

    task automatic fwd_off();
        ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
        mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        fwd_off();
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i;
        rf_mem[5] = 32'h1234;
        rf_mem[7] = 32'h7777;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid); end
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        checks++; if (out_pc !== 32'h0 || out_rs1_val !== 32'h0) begin errors++; $display("FAIL reset_payload got pc=%h rs1=%h exp 0", out_pc, out_rs1_val); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_regfile_read();
        @(negedge clk);
        drive(1'b1, 32'h100, 5'd5, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'h5555;
        #1;
        checks++; if (rf_read1 !== 5'd5 || rf_read2 !== 5'd0) begin errors++; $display("FAIL rf_addr got %0d/%0d exp 5/0", rf_read1, rf_read2); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready got %b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_valid got %b exp 1", out_valid); end
        checks++; if (out_rs1_val !== 32'h1234) begin errors++; $display("FAIL rf_rs1 got %h exp 1234", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h0) begin errors++; $display("FAIL rf_rs2_x0 got %h exp 0", out_rs2_val); end
        checks++; if (out_pc !== 32'h100 || out_imm !== 32'h104 || out_rd !== 5'd9 || out_rd_we !== 1'b1) begin
            errors++; $display("FAIL rf_payload got pc=%h imm=%h rd=%0d we=%b exp 100/104/9/1", out_pc, out_imm, out_rd, out_rd_we); end
        fwd_off();
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        drive(1'b1, 32'h140, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 32'hAAAA;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'hBBBB;
        step();
        checks++; if (out_valid !== 1'b1 || out_rs1_val !== 32'hAAAA) begin errors++; $display("FAIL fwd_ex got v=%b %h exp 1 AAAA", out_valid, out_rs1_val); end
        @(negedge clk);
        ex_fwd_valid = 1'b0;
        step();
        checks++; if (out_rs1_val !== 32'hBBBB) begin errors++; $display("FAIL fwd_mem got %h exp BBBB", out_rs1_val); end
        @(negedge clk);
        mem_fwd_valid = 1'b0;
        in_rs2 = 5'd1; in_use_rs2 = 1'b1;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd1; ex_fwd_data = 32'hC0DE;
        step();
        checks++; if (out_rs1_val !== 32'h7777) begin errors++; $display("FAIL fwd_rf got %h exp 7777", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'hC0DE) begin errors++; $display("FAIL fwd_link got %h exp C0DE", out_rs2_val); end
        fwd_off();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive(1'b1, 32'h1C0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
        step();
        checks++; if (out_valid !== 1'b1 || out_is_load !== 1'b1 || out_rd !== 5'd3) begin
            errors++; $display("FAIL lu_load got v=%b ld=%b rd=%0d exp 1/1/3", out_valid, out_is_load, out_rd); end
        @(negedge clk);
        drive(1'b1, 32'h200, 5'd0, 5'd3, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready got %b exp 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", out_valid); end
        checks++; if (stall_cnt !== 3'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
        @(negedge clk);
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hDEAD;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rs2_val !== 32'hDEAD || out_pc !== 32'h200) begin
            errors++; $display("FAIL lu_accept got v=%b rs2=%h pc=%h exp 1/DEAD/200", out_valid, out_rs2_val, out_pc); end
        fwd_off();
    endtask

    task automatic test_no_false_hazard();
        @(negedge clk);
        drive(1'b1, 32'h240, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        step();
        @(negedge clk);
        drive(1'b1, 32'h260, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nfh_x0 got %b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || stall_cnt !== 3'd1) begin errors++; $display("FAIL nfh_x0_out got v=%b cnt=%0d exp 1/1", out_valid, stall_cnt); end
        @(negedge clk);
        drive(1'b1, 32'h280, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
        step();
        @(negedge clk);
        drive(1'b1, 32'h2C0, 5'd6, 5'd2, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nfh_unused got %b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || stall_cnt !== 3'd1 || out_pc !== 32'h2C0) begin
            errors++; $display("FAIL nfh_unused_out got v=%b cnt=%0d pc=%h exp 1/1/2C0", out_valid, stall_cnt, out_pc); end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 5'd5, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h2C0 || out_rd !== 5'd4) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b pc=%h rd=%0d exp 1/2C0/4", i, out_valid, out_pc, out_rd); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
        step();
        checks++; if (out_pc !== 32'h300 || out_rs1_val !== 32'h1234 || out_rs2_val !== 32'h7777) begin
            errors++; $display("FAIL bp_next got pc=%h rs1=%h rs2=%h exp 300/1234/7777", out_pc, out_rs1_val, out_rs2_val); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(1'b1, 32'h400, 5'd5, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_not_accepted got %b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 32'h500, 5'd5, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
        step();
        checks++; if (out_valid !== 1'b1 || stall_cnt !== 3'd1) begin errors++; $display("FAIL ar_pre got v=%b cnt=%0d exp 1/1", out_valid, stall_cnt); end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 3'd0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL ar_async got v=%b cnt=%0d pc=%h exp 0/0/0", out_valid, stall_cnt, out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h600, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
            step();
            @(negedge clk);
            drive(1'b1, 32'h604, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
            step();
            checks++; if (stall_cnt !== CNT_W'((i > 7) ? 7 : i)) begin
                errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_cnt, (i > 7) ? 7 : i); end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_regfile_read();
        test_fwd_priority();
        test_load_use();
        test_no_false_hazard();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
